mr16_mem_arb: RTL

- Shares the mr16 subsystem's single synchronous program/data RAM (8 KB, 16-bit words) between the mr16 core memory bus and a host (Z80-side) request/acknowledge port.
- Steals one CPU clock-enable slot per host access by gating the core's clock enable, so the core needs no wait-state logic.
- Holds the CPU read data across a stolen slot.
- Enforces a minimum number of CPU slots between host slots to bound host bandwidth.

---
 rtl/mr16_mem_arb_if.sv | 39 +++
 rtl/mr16_mem_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mr16_mem_arb_if.sv
// rtl/mr16_mem_arb_if.sv - core, host and RAM signal bundle for mr16_mem_arb
interface mr16_mem_arb_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              I_CLKEN;
    logic              O_CPU_CLKEN;
    logic [15:0]       I_CPU_A;
    logic [15:0]       I_CPU_D;
    logic              I_CPU_WR;
    logic              I_CPU_CS;
    logic [15:0]       O_CPU_Q;
    logic              I_HOST_REQ;
    logic              I_HOST_WR;
    logic [ADDR_W-1:0] I_HOST_A;
    logic [15:0]       I_HOST_D;
    logic              O_HOST_ACK;
    logic [15:0]       O_HOST_Q;
    logic              O_HOST_ERR;
    logic [ADDR_W-1:0] O_RAM_A;
    logic [15:0]       O_RAM_D;
    logic              O_RAM_WE;
    logic [15:0]       I_RAM_Q;

    // Arbiter side
    modport slave (
        input  I_CLKEN, I_CPU_A, I_CPU_D, I_CPU_WR, I_CPU_CS,
        input  I_HOST_REQ, I_HOST_WR, I_HOST_A, I_HOST_D, I_RAM_Q,
        output O_CPU_CLKEN, O_CPU_Q, O_HOST_ACK, O_HOST_Q, O_HOST_ERR,
        output O_RAM_A, O_RAM_D, O_RAM_WE
    );

    // Environment side: core, host and RAM
    modport master (
        output I_CLKEN, I_CPU_A, I_CPU_D, I_CPU_WR, I_CPU_CS,
        output I_HOST_REQ, I_HOST_WR, I_HOST_A, I_HOST_D, I_RAM_Q,
        input  O_CPU_CLKEN, O_CPU_Q, O_HOST_ACK, O_HOST_Q, O_HOST_ERR,
        input  O_RAM_A, O_RAM_D, O_RAM_WE
    );
endinterface

// File: rtl/mr16_mem_arb.sv
// rtl/mr16_mem_arb.sv - cycle-stealing RAM arbiter between mr16 core and host; MR16_ARB_WPROT_EN enables host write protection
module mr16_mem_arb #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned CPU_GAP    = 3,
    parameter int unsigned PROT_WORDS = 256
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    mr16_mem_arb_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_HOST_DONE = 1'b1
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(CPU_GAP);

    state_t            state_q, state_d;
    logic [3:0]        gap_q, gap_d;
    logic              last_cpu_q, last_cpu_d;
    logic [15:0]       cpu_hold_q, cpu_hold_d;
    logic [15:0]       host_q_q, host_q_d;
    logic              slot_wr_q, slot_wr_d;
    logic              host_slot;
    logic              host_prot;
    logic [ADDR_W-1:0] cpu_word_a;
    logic              unused_cpu_a;

    assign cpu_word_a   = bus.I_CPU_A[ADDR_W:1];
    assign unused_cpu_a = ^{bus.I_CPU_A[15:ADDR_W+1], bus.I_CPU_A[0]};

`ifdef MR16_ARB_WPROT_EN
    logic slot_err_q, slot_err_d;

    // Host writes into the low protected window are dropped but still take a slot
    assign host_prot = bus.I_HOST_WR &
                       ({{(32-ADDR_W){1'b0}}, bus.I_HOST_A} < PROT_WORDS);
    assign slot_err_d = host_slot ? host_prot : slot_err_q;
    assign bus.O_HOST_ERR = (state_q == ST_HOST_DONE) & slot_err_q;

    // Error flag of the slot just served, reported alongside ACK
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            slot_err_q <= 1'b0;
        end else begin
            slot_err_q <= slot_err_d;
        end
    end
`else
    localparam int unsigned unused_prot_words = PROT_WORDS;

    assign host_prot      = 1'b0;
    assign bus.O_HOST_ERR = 1'b0;
`endif

    // A core read issued just before a stolen slot is replayed from cpu_hold
    assign bus.O_CPU_Q = last_cpu_q ? bus.I_RAM_Q : cpu_hold_q;
    assign last_cpu_d  = ~host_slot;

    // State register and datapath registers
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q    <= ST_IDLE;
            gap_q      <= 4'd0;
            last_cpu_q <= 1'b1;
            cpu_hold_q <= 16'h0000;
            host_q_q   <= 16'h0000;
            slot_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            last_cpu_q <= last_cpu_d;
            cpu_hold_q <= cpu_hold_d;
            host_q_q   <= host_q_d;
            slot_wr_q  <= slot_wr_d;
        end
    end

    // Next state, RAM mux, core enable gating and host handshake
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        cpu_hold_d = cpu_hold_q;
        host_q_d   = host_q_q;
        slot_wr_d  = slot_wr_q;
        host_slot  = 1'b0;

        bus.O_CPU_CLKEN = bus.I_CLKEN;
        bus.O_RAM_A     = cpu_word_a;
        bus.O_RAM_D     = bus.I_CPU_D;
        bus.O_RAM_WE    = bus.I_CPU_CS & bus.I_CPU_WR & bus.I_CLKEN;
        bus.O_HOST_ACK  = 1'b0;
        bus.O_HOST_Q    = host_q_q;

        if (last_cpu_q) begin
            cpu_hold_d = bus.I_RAM_Q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.I_CLKEN && bus.I_HOST_REQ && (gap_q == 4'd0)) begin
                    host_slot       = 1'b1;
                    bus.O_CPU_CLKEN = 1'b0;
                    bus.O_RAM_A     = bus.I_HOST_A;
                    bus.O_RAM_D     = bus.I_HOST_D;
                    bus.O_RAM_WE    = bus.I_HOST_WR & ~host_prot;
                    state_d         = ST_HOST_DONE;
                    gap_d           = GAP_LOAD;
                    slot_wr_d       = bus.I_HOST_WR;
                end else if (bus.I_CLKEN && (gap_q != 4'd0)) begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_HOST_DONE: begin
                bus.O_HOST_ACK = 1'b1;
                if (!slot_wr_q) begin
                    bus.O_HOST_Q = bus.I_RAM_Q;
                    host_q_d     = bus.I_RAM_Q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
